// File: rtl/uart_pkg.sv
// Shared UART definitions: word-sender FSM states and byte/word geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        SEND     = 2'd2,
        HOLD     = 2'd3
    } sender_state_t;

    localparam int UART_BYTES_PER_WORD = 4;
    localparam int UART_BYTE_W         = 8;
    localparam int UART_WORD_W         = UART_BYTES_PER_WORD * UART_BYTE_W;

endpackage

// File: rtl/word_fifo.sv
// Parameterised synchronous FIFO with registered read, usable on both UART directions.
module word_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic              wr_ok;
    logic              rd_ok;

    assign full  = (count_reg == (ADDR_W + 1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign rd_ok = rd_en && !empty;
    // A pop in the same cycle frees a slot, so a write to a full FIFO is still taken.
    assign wr_ok = wr_en && (!full || rd_ok);

    // Read-before-write on a shared address keeps the popped word intact when full.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
        if (rd_ok) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + (ADDR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (ADDR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;

endmodule

// File: rtl/uart_word_sender.sv
// Buffers 32-bit words and feeds them bytewise to the UART byte sender.
// Define UART_WORD_SENDER_LE_ORDER_EN to send bytes LSB first instead of MSB first.
module uart_word_sender
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [UART_WORD_W-1:0]     in_data,
    input  logic                       in_enable,
    input  logic                       sender_ready,
    output logic [UART_BYTE_W-1:0]     sender_data,
    output logic                       sender_enable,
    output logic                       busy,
    output logic                       full,
    output logic                       overflow,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);

    sender_state_t            state_reg, state_next;
    logic [UART_WORD_W-1:0]   shift_reg, shift_next;
    logic [1:0]               byte_cnt_reg, byte_cnt_next;
    logic [UART_BYTE_W-1:0]   sender_data_reg, sender_data_next;
    logic                     sender_enable_reg, sender_enable_next;
    logic                     overflow_reg;
    logic                     fresh_reg;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [UART_WORD_W-1:0]   fifo_rd_data;
    logic [UART_WORD_W-1:0]   cur_word;
    logic [UART_WORD_W-1:0]   shifted_word;
    logic [UART_BYTE_W-1:0]   cur_byte;

    word_fifo #(
        .DATA_W (UART_WORD_W),
        .ADDR_W (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .wr_en   (in_enable),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The FIFO read is registered, so the popped word is taken from its output for one cycle.
    assign cur_word = fresh_reg ? fifo_rd_data : shift_reg;

`ifdef UART_WORD_SENDER_LE_ORDER_EN
    assign cur_byte     = cur_word[UART_BYTE_W-1:0];
    assign shifted_word = {{UART_BYTE_W{1'b0}}, cur_word[UART_WORD_W-1:UART_BYTE_W]};
`else
    assign cur_byte     = cur_word[UART_WORD_W-1 -: UART_BYTE_W];
    assign shifted_word = {cur_word[UART_WORD_W-UART_BYTE_W-1:0], {UART_BYTE_W{1'b0}}};
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (!fifo_empty) state_next = WAIT_RDY;
            WAIT_RDY: if (sender_ready) state_next = SEND;
            SEND:     state_next = HOLD;
            HOLD:     state_next = (byte_cnt_reg == 2'(UART_BYTES_PER_WORD - 1)) ? IDLE : WAIT_RDY;
            default:  state_next = IDLE;
        endcase
    end

    // Outputs are computed one cycle early so sender_enable/sender_data come straight from flops.
    always_comb begin
        pop                = 1'b0;
        shift_next         = cur_word;
        byte_cnt_next      = byte_cnt_reg;
        sender_enable_next = 1'b0;
        sender_data_next   = sender_data_reg;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    byte_cnt_next = 2'd0;
                end
            end
            WAIT_RDY: begin
                if (sender_ready) begin
                    sender_enable_next = 1'b1;
                    sender_data_next   = cur_byte;
                end
            end
            HOLD: begin
                if (byte_cnt_reg != 2'(UART_BYTES_PER_WORD - 1)) begin
                    shift_next    = shifted_word;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            shift_reg         <= '0;
            fresh_reg         <= 1'b0;
            byte_cnt_reg      <= 2'd0;
            sender_data_reg   <= '0;
            sender_enable_reg <= 1'b0;
            overflow_reg      <= 1'b0;
        end else begin
            shift_reg         <= shift_next;
            fresh_reg         <= pop;
            byte_cnt_reg      <= byte_cnt_next;
            sender_data_reg   <= sender_data_next;
            sender_enable_reg <= sender_enable_next;
            overflow_reg      <= overflow_reg | (in_enable & fifo_full & ~pop);
        end
    end

    assign sender_data   = sender_data_reg;
    assign sender_enable = sender_enable_reg;
    assign overflow      = overflow_reg;
    assign full          = fifo_full;
    assign busy          = (state_reg != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_word_sender.sv
// Self-checking bench for uart_word_sender: directed scenarios plus randomized traffic vs a byte-queue model.
module tb_uart_word_sender;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = 32'h0;
    logic        in_enable = 1'b0;
    logic        sender_ready;
    logic [7:0]  sender_data;
    logic        sender_enable;
    logic        busy;
    logic        full;
    logic        overflow;
    logic [4:0]  fifo_count;

    uart_word_sender #(.FIFO_DEPTH_LOG2(4)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .in_data       (in_data),
        .in_enable     (in_enable),
        .sender_ready  (sender_ready),
        .sender_data   (sender_data),
        .sender_enable (sender_enable),
        .busy          (busy),
        .full          (full),
        .overflow      (overflow),
        .fifo_count    (fifo_count)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int strobe_cnt = 0;
    int last_strobe_cyc = 0;
    int wr_cyc = 0;
    logic ready_allow = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Expected byte stream for one accepted word.
    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
`ifdef UART_WORD_SENDER_LE_ORDER_EN
            exp_q.push_back(w[8*i +: 8]);
`else
            exp_q.push_back(w[31-8*i -: 8]);
`endif
        end
    endtask

    // Byte sender model: busy for 2 cycles after each strobe, plus a bench-controlled gate.
    assign sender_ready = ready_allow && (busy_cnt == 0);

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        #1;
        if (sender_enable === 1'b1) begin
            strobe_cnt++;
            last_strobe_cyc = cyc;
            busy_cnt = 2;
            if (exp_q.size() == 0)
                check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            else
                check("byte", {24'h0, sender_data}, {24'h0, exp_q.pop_front()});
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1;
        in_enable = 1'b0;
        @(negedge CLK);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic write_word(input logic [31:0] w);
        in_data = w;
        in_enable = 1'b1;
        wr_cyc = cyc;
        push_word(w);
        @(negedge CLK);
        in_enable = 1'b0;
    endtask

    task automatic fill_words(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            in_data = w;
            in_enable = 1'b1;
            push_word(w);
            @(negedge CLK);
        end
        in_enable = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int max_cycles, input string tag);
        int n;
        n = 0;
        while (strobe_cnt < target && n < max_cycles) begin
            @(negedge CLK);
            n++;
        end
        check(tag, 32'(strobe_cnt), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int base2;
        int n;
        logic [31:0] w;
        logic [7:0] last_b;

        // Reset state and single-word latency/order
        do_reset();
        check("rst_enable", 32'(sender_enable), 32'd0);
        check("rst_data", {24'h0, sender_data}, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        ready_allow = 1'b1;
        base = strobe_cnt;
        write_word(32'h12345678);
        wait_strobes(base + 1, 20, "t1_first_strobe");
        check("t1_latency", 32'(last_strobe_cyc - wr_cyc), 32'd3);
        wait_strobes(base + 4, 40, "t1_all_strobes");
        @(negedge CLK);
        check("t1_busy_in_hold", 32'(busy), 32'd1);
        @(negedge CLK);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_enable_low", 32'(sender_enable), 32'd0);
`ifdef UART_WORD_SENDER_LE_ORDER_EN
        last_b = 8'h12;
`else
        last_b = 8'h78;
`endif
        check("t1_data_held", {24'h0, sender_data}, {24'h0, last_b});

        // Fill to full with ready low, then overflow on the 18th write
        do_reset();
        ready_allow = 1'b0;
        base = strobe_cnt;
        fill_words(17);
        check("t2_count_full", 32'(fifo_count), 32'd16);
        check("t2_full", 32'(full), 32'd1);
        check("t2_no_overflow_yet", 32'(overflow), 32'd0);
        in_data = $urandom;
        in_enable = 1'b1;
        @(negedge CLK);
        in_enable = 1'b0;
        check("t2_overflow", 32'(overflow), 32'd1);
        check("t2_count_after_drop", 32'(fifo_count), 32'd16);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_no_strobe", 32'(strobe_cnt), 32'(base));
        ready_allow = 1'b1;
        wait_strobes(base + 68, 400, "t2_drain");
        repeat (3) @(negedge CLK);
        check("t2_idle_busy", 32'(busy), 32'd0);
        check("t2_idle_count", 32'(fifo_count), 32'd0);
        check("t2_overflow_sticky", 32'(overflow), 32'd1);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Full FIFO with simultaneous pop and write
        do_reset();
        ready_allow = 1'b0;
        fill_words(17);
        base = strobe_cnt;
        ready_allow = 1'b1;
        wait_strobes(base + 4, 30, "t3_first_word");
        @(negedge CLK);
        @(negedge CLK);
        w = 32'hDEADBEEF;
        in_data = w;
        in_enable = 1'b1;
        push_word(w);
        @(negedge CLK);
        in_enable = 1'b0;
        check("t3_count_kept", 32'(fifo_count), 32'd16);
        check("t3_full_kept", 32'(full), 32'd1);
        check("t3_no_overflow", 32'(overflow), 32'd0);
        wait_strobes(base + 72, 400, "t3_drain");
        repeat (3) @(negedge CLK);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t3_overflow_final", 32'(overflow), 32'd0);

        // Reset in the middle of a word with three words queued
        do_reset();
        ready_allow = 1'b1;
        base = strobe_cnt;
        in_data = 32'hAABBCCDD;
        in_enable = 1'b1;
        push_word(32'hAABBCCDD);
        @(negedge CLK);
        in_enable = 1'b0;
        fill_words(3);
        wait_strobes(base + 2, 30, "t4_two_bytes");
        check("t4_queued", 32'(fifo_count), 32'd3);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        exp_q.delete();
        check("t4_enable", 32'(sender_enable), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_count", 32'(fifo_count), 32'd0);
        check("t4_overflow", 32'(overflow), 32'd0);
        base2 = strobe_cnt;
        repeat (40) @(negedge CLK);
        check("t4_no_more_strobes", 32'(strobe_cnt), 32'(base2));

        // Ready held low in WAIT_RDY, before the first byte and mid-word
        do_reset();
        ready_allow = 1'b0;
        base = strobe_cnt;
        write_word(32'hCAFEF00D);
        repeat (50) @(negedge CLK);
        check("t5_stall_first", 32'(strobe_cnt), 32'(base));
        check("t5_busy_stalled", 32'(busy), 32'd1);
        ready_allow = 1'b1;
        wait_strobes(base + 1, 10, "t5_first_byte");
        ready_allow = 1'b0;
        repeat (50) @(negedge CLK);
        check("t5_stall_mid", 32'(strobe_cnt), 32'(base + 1));
        ready_allow = 1'b1;
        wait_strobes(base + 4, 30, "t5_rest");
        repeat (20) @(negedge CLK);
        check("t5_exact_count", 32'(strobe_cnt), 32'(base + 4));

        // Randomized traffic, never enough outstanding words to fill the FIFO
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ready_allow = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && exp_q.size() <= 60) begin
                w = $urandom;
                in_data = w;
                in_enable = 1'b1;
                push_word(w);
            end else begin
                in_enable = 1'b0;
            end
            @(negedge CLK);
        end
        in_enable = 1'b0;
        ready_allow = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("t6_drained", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge CLK);
        check("t6_busy_end", 32'(busy), 32'd0);
        check("t6_no_overflow", 32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
